redmule_ldst_arbiter: RTL and testbench

REDMULE_LDST_ARBITER -- requirements
Module: redmule_ldst_arbiter

---
 rtl/redmule_pkg.sv | 18 +
 rtl/redmule_ldst_id_fifo.sv | 53 +++++
 rtl/redmule_ldst_arbiter.sv | 166 ++++++++++++++++
 tb/tb_redmule_ldst_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/redmule_pkg.sv
// rtl/redmule_pkg.sv - shared types and default parameters for the RedMulE load/store arbiter
// Purpose : arbitration-mode enum and the default parameter constants used by the
//           arbiter top and its id FIFO.
// Ports   : none (package).
package redmule_pkg;

   typedef enum logic {
      ARB_RR      = 1'b0,   // round-robin over all channels
      ARB_ST_PRIO = 1'b1    // stores first, loads only when no store is eligible
   } arb_mode_e;

   localparam int unsigned NUM_LD_DEF    = 3;
   localparam int unsigned NUM_ST_DEF    = 1;
   localparam int unsigned DW_DEF        = 288;
   localparam int unsigned AW_DEF        = 32;
   localparam int unsigned MAX_OUTST_DEF = 4;

endpackage

// File: rtl/redmule_ldst_id_fifo.sv
// rtl/redmule_ldst_id_fifo.sv - in-order FIFO of load channel ids awaiting a response
// Purpose : remembers which load channel issued each outstanding load so responses,
//           which return in order, can be routed back.
// Ports   : clk, rst (sync, active-high, also used for soft clear),
//           push/push_id (write), pop/pop_id (read head), full, empty, count.
module redmule_ldst_id_fifo
   import redmule_pkg::*;
#(
   parameter int unsigned Depth = MAX_OUTST_DEF,
   parameter int unsigned IdW   = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [IdW-1:0]               push_id,
   input  logic                         pop,
   output logic [IdW-1:0]               pop_id,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(Depth+1)-1:0]   count
);

   localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CW = $clog2(Depth + 1);

   logic [IdW-1:0] mem_q [Depth];
   logic [PW-1:0]  wr_q, rd_q;
   logic           push_ok, pop_ok;

   assign full    = (count == CW'(Depth));
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign pop_id  = mem_q[rd_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         count <= '0;
         for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_q] <= push_id;
            wr_q        <= (wr_q == PW'(Depth - 1)) ? '0 : wr_q + 1'b1;
         end
         if (pop_ok) rd_q <= (rd_q == PW'(Depth - 1)) ? '0 : rd_q + 1'b1;
         if (push_ok && !pop_ok)      count <= count + 1'b1;
         else if (!push_ok && pop_ok) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/redmule_ldst_arbiter.sv
// rtl/redmule_ldst_arbiter.sv - arbitrates load/store channels onto one TCDM port
// Purpose : picks one requesting channel per cycle (round-robin or store priority),
//           holds it while the memory stalls, and routes in-order load responses back.
// Ports   : clk_i, rst_i (sync, active-high), clear_i (soft clear), mode_i;
//           ch_req_i/ch_gnt_o/ch_add_i per channel, ch_data_i/ch_be_i per store channel;
//           ch_r_valid_o per load channel, ch_r_data_o shared; tcdm_* memory port;
//           outst_o outstanding loads, busy_o, err_o sticky stray-response flag.
module redmule_ldst_arbiter
   import redmule_pkg::*;
#(
   parameter int unsigned NumLd    = NUM_LD_DEF,
   parameter int unsigned NumSt    = NUM_ST_DEF,
   parameter int unsigned DW       = DW_DEF,
   parameter int unsigned AW       = AW_DEF,
   parameter int unsigned MaxOutst = MAX_OUTST_DEF
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              clear_i,
   input  logic                              mode_i,
   input  logic [NumLd+NumSt-1:0]            ch_req_i,
   output logic [NumLd+NumSt-1:0]            ch_gnt_o,
   input  logic [(NumLd+NumSt)*AW-1:0]       ch_add_i,
   input  logic [NumSt*DW-1:0]               ch_data_i,
   input  logic [NumSt*(DW/8)-1:0]           ch_be_i,
   output logic [NumLd-1:0]                  ch_r_valid_o,
   output logic [DW-1:0]                     ch_r_data_o,
   output logic                              tcdm_req_o,
   input  logic                              tcdm_gnt_i,
   output logic [AW-1:0]                     tcdm_add_o,
   output logic                              tcdm_wen_o,
   output logic [DW-1:0]                     tcdm_data_o,
   output logic [DW/8-1:0]                   tcdm_be_o,
   input  logic                              tcdm_r_valid_i,
   input  logic [DW-1:0]                     tcdm_r_data_i,
   output logic [$clog2(MaxOutst+1)-1:0]     outst_o,
   output logic                              busy_o,
   output logic                              err_o
);

   localparam int unsigned N  = NumLd + NumSt;
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned BW = DW / 8;

   logic [IW-1:0] rr_ptr_q, lock_id_q, sel_id, win_id, head_id;
   logic          lock_q, err_q, sel_valid, active, done, win_st, push, resp;
   logic          soft_rst, fifo_full, fifo_empty;
   logic [AW-1:0] add_q;
   logic [DW-1:0] data_q;
   logic [BW-1:0] be_q;
   logic [N-1:0]  elig, cand;

   // Requests are suppressed during reset/clear so nothing is issued whose id
   // would be dropped by the FIFO flush.
   assign soft_rst = rst_i | clear_i;

   // Eligibility and rotating first-fit selection starting at rr_ptr.
   always_comb begin
      int idx;
      idx       = 0;
      elig      = '0;
      sel_valid = 1'b0;
      sel_id    = '0;
      for (int i = 0; i < int'(N); i++)
         elig[i] = ch_req_i[i] & ((i >= int'(NumLd)) | ~fifo_full);
      cand = elig;
      if (arb_mode_e'(mode_i) == ARB_ST_PRIO && |(elig >> NumLd))
         cand = (elig >> NumLd) << NumLd;
      for (int k = 0; k < int'(N); k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= int'(N)) idx = idx - int'(N);
         if (!sel_valid && cand[idx]) begin
            sel_valid = 1'b1;
            sel_id    = IW'(idx);
         end
      end
   end

   assign active = ~soft_rst & (lock_q | sel_valid);
   assign win_id = lock_q ? lock_id_q : sel_id;
   assign win_st = (32'(win_id) >= NumLd);
   assign done   = active & tcdm_gnt_i;
   assign push   = done & ~win_st;

   // Memory-side request: registered copy while locked, live channel otherwise.
   always_comb begin
      tcdm_req_o  = active;
      tcdm_add_o  = '0;
      tcdm_wen_o  = 1'b0;
      tcdm_data_o = '0;
      tcdm_be_o   = '1;
      ch_gnt_o    = '0;
      if (active) begin
         tcdm_wen_o = ~win_st;
         if (lock_q) begin
            tcdm_add_o  = add_q;
            tcdm_data_o = data_q;
            tcdm_be_o   = be_q;
         end else begin
            for (int i = 0; i < int'(N); i++)
               if (sel_id == IW'(i)) tcdm_add_o = ch_add_i[i*AW +: AW];
            for (int s = 0; s < int'(NumSt); s++)
               if (sel_id == IW'(int'(NumLd) + s)) begin
                  tcdm_data_o = ch_data_i[s*DW +: DW];
                  tcdm_be_o   = ch_be_i[s*BW +: BW];
               end
         end
         for (int i = 0; i < int'(N); i++)
            ch_gnt_o[i] = tcdm_gnt_i & (win_id == IW'(i));
      end
   end

   // Responses return in order; the FIFO head names the owning load channel.
   assign resp = ~soft_rst & tcdm_r_valid_i & ~fifo_empty;

   always_comb begin
      ch_r_valid_o = '0;
      for (int i = 0; i < int'(NumLd); i++)
         ch_r_valid_o[i] = resp & (head_id == IW'(i));
      ch_r_data_o = resp ? tcdm_r_data_i : '0;
   end

   always_ff @(posedge clk_i) begin
      if (soft_rst) begin
         rr_ptr_q  <= '0;
         lock_q    <= 1'b0;
         lock_id_q <= '0;
         add_q     <= '0;
         data_q    <= '0;
         be_q      <= '1;
         err_q     <= 1'b0;
      end else begin
         if (done) begin
            rr_ptr_q <= (win_id == IW'(N - 1)) ? '0 : win_id + 1'b1;
            lock_q   <= 1'b0;
         end else if (active) begin
            // Stalled: freeze the winner and its payload until the grant.
            lock_q    <= 1'b1;
            lock_id_q <= win_id;
            add_q     <= tcdm_add_o;
            data_q    <= tcdm_data_o;
            be_q      <= tcdm_be_o;
         end
         if (tcdm_r_valid_i && fifo_empty) err_q <= 1'b1;
      end
   end

   redmule_ldst_id_fifo #(
      .Depth (MaxOutst),
      .IdW   (IW)
   ) i_id_fifo (
      .clk     (clk_i),
      .rst     (soft_rst),
      .push    (push),
      .push_id (win_id),
      .pop     (resp),
      .pop_id  (head_id),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (outst_o)
   );

   assign err_o  = err_q;
   assign busy_o = (outst_o != '0) | tcdm_req_o;

endmodule

// File: tb/tb_redmule_ldst_arbiter.sv
// tb/tb_redmule_ldst_arbiter.sv - directed self-checking bench for redmule_ldst_arbiter
module tb_redmule_ldst_arbiter;

   logic        clk = 1'b0;
   logic        rst, clear, mode;
   logic [3:0]  ch_req, ch_gnt;
   logic [127:0] ch_add;
   logic [31:0] ch_data;
   logic [3:0]  ch_be;
   logic [2:0]  ch_r_valid;
   logic [31:0] ch_r_data;
   logic        tcdm_req, tcdm_gnt, tcdm_wen, tcdm_r_valid;
   logic [31:0] tcdm_add, tcdm_data, tcdm_r_data;
   logic [3:0]  tcdm_be;
   logic [2:0]  outst;
   logic        busy, err;

   int total = 0;
   int bad   = 0;

   logic [3:0]  rr_exp [5]  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
   logic [2:0]  rv_exp [3]  = '{3'b010, 3'b001, 3'b100};
   logic [31:0] rd_val [3]  = '{32'hD1D1_0001, 32'hD2D2_0002, 32'hD3D3_0003};

   always #5 clk = ~clk;

   redmule_ldst_arbiter #(
      .NumLd(3), .NumSt(1), .DW(32), .AW(32), .MaxOutst(4)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .clear_i        (clear),
      .mode_i         (mode),
      .ch_req_i       (ch_req),
      .ch_gnt_o       (ch_gnt),
      .ch_add_i       (ch_add),
      .ch_data_i      (ch_data),
      .ch_be_i        (ch_be),
      .ch_r_valid_o   (ch_r_valid),
      .ch_r_data_o    (ch_r_data),
      .tcdm_req_o     (tcdm_req),
      .tcdm_gnt_i     (tcdm_gnt),
      .tcdm_add_o     (tcdm_add),
      .tcdm_wen_o     (tcdm_wen),
      .tcdm_data_o    (tcdm_data),
      .tcdm_be_o      (tcdm_be),
      .tcdm_r_valid_i (tcdm_r_valid),
      .tcdm_r_data_i  (tcdm_r_data),
      .outst_o        (outst),
      .busy_o         (busy),
      .err_o          (err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; mode = 1'b0; ch_req = 4'h0;
      ch_add  = {32'h1300, 32'h1200, 32'h1100, 32'h1000};
      ch_data = 32'hCAFE_0003; ch_be = 4'h5;
      tcdm_gnt = 1'b0; tcdm_r_valid = 1'b0; tcdm_r_data = '0;
      tick(); tick();
      ch_req = 4'hF;
      #1;
      chk("rst_req", tcdm_req, 0);
      chk("rst_gnt", ch_gnt, 0);
      chk("rst_outst", outst, 0);
      chk("rst_err", err, 0);
      chk("rst_be", tcdm_be, 4'hF);
      chk("rst_busy", busy, 0);
      chk("rst_rvalid", ch_r_valid, 0);
      rst = 1'b0; ch_req = 4'h0;
      tick();

      // round-robin fairness
      mode = 1'b0; tcdm_gnt = 1'b1; ch_req = 4'hF;
      #1;
      chk("rr_add0", tcdm_add, 32'h1000);
      chk("rr_wen0", tcdm_wen, 1);
      for (int i = 0; i < 5; i++) begin
         #1 chk("rr_gnt", ch_gnt, rr_exp[i]);
         tick();
      end
      chk("lim_outst", outst, 4);
      #1;
      chk("lim_st_gnt", ch_gnt, 4'h8);
      chk("lim_st_wen", tcdm_wen, 0);
      tick();
      chk("lim_outst2", outst, 4);
      ch_req = 4'h1;
      #1;
      chk("lim_ld_blk", ch_gnt, 0);
      chk("lim_req", tcdm_req, 0);
      chk("lim_busy", busy, 1);
      tcdm_r_valid = 1'b1; tcdm_r_data = 32'hD0;
      #1;
      chk("lim_rvalid", ch_r_valid, 3'b001);
      chk("lim_rdata", ch_r_data, 32'hD0);
      chk("lim_full_pop_blk", ch_gnt, 0);
      tick();
      tcdm_r_valid = 1'b0;
      chk("lim_outst3", outst, 3);
      #1 chk("lim_resume", ch_gnt, 4'h1);
      tick();
      chk("lim_outst4", outst, 4);
      clear = 1'b1; ch_req = 4'h0;
      tick();
      clear = 1'b0;
      chk("clr_outst", outst, 0);
      chk("clr_busy", busy, 0);

      // store priority
      mode = 1'b1; ch_req = 4'b1001;
      for (int i = 0; i < 3; i++) begin
         #1 chk("sp_gnt", ch_gnt, 4'h8);
         tick();
      end
      chk("sp_outst", outst, 0);

      // back-pressure lock
      mode = 1'b0; ch_req = 4'b1000; tcdm_gnt = 1'b0;
      #1;
      chk("lk_req", tcdm_req, 1);
      chk("lk_gnt0", ch_gnt, 0);
      chk("lk_add0", tcdm_add, 32'h1300);
      tick();
      ch_req = 4'b1100; ch_data = 32'hBEEF_0000; ch_be = 4'hA;
      ch_add[127:96] = 32'h3333;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("lk_add", tcdm_add, 32'h1300);
         chk("lk_data", tcdm_data, 32'hCAFE_0003);
         chk("lk_be", tcdm_be, 4'h5);
         chk("lk_wen", tcdm_wen, 0);
         chk("lk_gnt", ch_gnt, 0);
         tick();
      end
      tcdm_gnt = 1'b1;
      #1;
      chk("lk_rel_gnt", ch_gnt, 4'h8);
      chk("lk_rel_data", tcdm_data, 32'hCAFE_0003);
      tick();
      ch_add[127:96] = 32'h1300; ch_req = 4'b0100;
      #1;
      chk("ld2_gnt", ch_gnt, 4'h4);
      chk("ld2_wen", tcdm_wen, 1);
      chk("ld2_data", tcdm_data, 0);
      chk("ld2_be", tcdm_be, 4'hF);
      chk("ld2_add", tcdm_add, 32'h1200);
      tick();
      chk("ld2_outst", outst, 1);

      // response routing, with a same-cycle push and pop first
      ch_req = 4'b0010; tcdm_r_valid = 1'b1; tcdm_r_data = 32'hD0D0;
      #1;
      chk("rt_gnt1", ch_gnt, 4'h2);
      chk("rt_pp_rvalid", ch_r_valid, 3'b100);
      chk("rt_pp_rdata", ch_r_data, 32'hD0D0);
      tick();
      tcdm_r_valid = 1'b0;
      chk("rt_pp_outst", outst, 1);
      ch_req = 4'b0001;
      #1 chk("rt_gnt0", ch_gnt, 4'h1);
      tick();
      ch_req = 4'b0100;
      #1 chk("rt_gnt2", ch_gnt, 4'h4);
      tick();
      ch_req = 4'h0; tcdm_gnt = 1'b0;
      chk("rt_outst", outst, 3);
      for (int i = 0; i < 3; i++) begin
         tcdm_r_valid = 1'b1; tcdm_r_data = rd_val[i];
         #1;
         chk("rt_rvalid", ch_r_valid, rv_exp[i]);
         chk("rt_rdata", ch_r_data, rd_val[i]);
         tick();
      end
      tcdm_r_valid = 1'b0;
      chk("rt_outst0", outst, 0);
      chk("rt_err0", err, 0);

      // stray response, then reset in the middle of a transfer
      tcdm_r_valid = 1'b1;
      #1 chk("er_rvalid", ch_r_valid, 0);
      tick();
      tcdm_r_valid = 1'b0;
      chk("er_err", err, 1);
      ch_req = 4'b0010; tcdm_gnt = 1'b1;
      #1 chk("er_gnt1", ch_gnt, 4'h2);
      tick();
      chk("er_outst", outst, 1);
      ch_req = 4'b0001; tcdm_gnt = 1'b0;
      #1 chk("er_pend", tcdm_req, 1);
      tick();
      rst = 1'b1;
      #1 chk("er_rst_req", tcdm_req, 0);
      tick();
      rst = 1'b0; ch_req = 4'h0;
      #1;
      chk("er_rst_err", err, 0);
      chk("er_rst_outst", outst, 0);
      chk("er_rst_busy", busy, 0);
      tcdm_r_valid = 1'b1;
      #1 chk("ab_rvalid", ch_r_valid, 0);
      tick();
      tcdm_r_valid = 1'b0;
      chk("ab_err", err, 1);
      ch_req = 4'hF; tcdm_gnt = 1'b1;
      #1 chk("ab_rr_ptr0", ch_gnt, 4'h1);
      tick();
      ch_req = 4'h0; tcdm_gnt = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
